fetch_sequencer: RTL and testbench

Controller that sequences instruction fetch for the core: owns the program counter and issues reads to the single-ported instruction memory. It tags each returning word with its PC and buffers it in a small queue that decode drains with a valid/ready handshake. Branch or jump redirects from execute flush all queued and in-flight fetches. The block sits between the instruction memory port and the decode stage and replaces free-running PC+4 fetch with credit-based, stall-tolerant sequencing.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
//   state_t            : sequencer FSM states (TRAP only reachable with
//                        FETCH_SEQ_MISALIGN_TRAP_EN defined)
//   INST_W / PC_W      : instruction and program-counter widths
//   PC_STEP            : sequential fetch increment
//   DEFAULT_RESET_ADDR : default PC after reset
//   align_word()       : clears the byte-offset bits of an address
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [PC_W-1:0] PC_STEP            = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, inst} pairs between fetch and decode.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_push, i_push_pc,
//   i_push_inst         : write one entry
//   i_pop               : remove the head entry (caller guarantees non-empty)
//   i_flush             : discard all entries; wins over a same-cycle push/pop
//   o_head_pc/inst      : head entry, read combinationally from storage
//   o_count, o_full,
//   o_empty             : occupancy
// Storage is cleared on reset so the head outputs are never X afterwards.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [PC_W-1:0]   i_push_pc,
    input  logic [INST_W-1:0] i_push_inst,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [PC_W-1:0]   o_head_pc,
    output logic [INST_W-1:0] o_head_inst,
    output logic [AW:0]       o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (i_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (i_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({i_push, i_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    pc_mem[gi]   <= '0;
                    inst_mem[gi] <= '0;
                end else if (i_push && !i_flush && (wr_ptr_reg == AW'(gi))) begin
                    pc_mem[gi]   <= i_push_pc;
                    inst_mem[gi] <= i_push_inst;
                end
            end
        end
    endgenerate

    assign o_head_pc   = pc_mem[rd_ptr_reg];
    assign o_head_inst = inst_mem[rd_ptr_reg];
    assign o_count     = count_reg;
    assign o_empty     = (count_reg == '0);
    assign o_full      = (count_reg == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues single-ported instruction memory reads
// under a credit rule (queued + in-flight never exceeds QUEUE_DEPTH), tags
// returning words with their PC and hands them to decode via valid/ready.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_redirect, i_redirect_addr  : taken branch/jump from execute; flushes
//   o_imem_ren, o_imem_raddr     : memory read request
//   i_imem_rdata                 : read data, one cycle after the request
//   o_inst_valid, o_inst,
//   o_inst_pc, i_inst_ready      : decode handshake (queue head)
//   o_misaligned                 : misaligned-redirect trap flag
// Optional feature macro: FETCH_SEQ_MISALIGN_TRAP_EN. When defined, a redirect
// to a non-word-aligned address enters TRAP; otherwise the low address bits
// are cleared and o_misaligned is tied low.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_ADDR  = DEFAULT_RESET_ADDR,
    parameter int              QUEUE_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_redirect,
    input  logic [PC_W-1:0]   i_redirect_addr,
    output logic              o_imem_ren,
    output logic [PC_W-1:0]   o_imem_raddr,
    input  logic [INST_W-1:0] i_imem_rdata,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [PC_W-1:0]   o_inst_pc,
    input  logic              i_inst_ready,
    output logic              o_misaligned
);

    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = AW + 2;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] tag_reg, tag_next;
    logic            inflight_reg, inflight_next;

    logic              q_push, q_pop, q_full, q_empty;
    logic [AW:0]       q_count;
    logic [PC_W-1:0]   q_head_pc;
    logic [INST_W-1:0] q_head_inst;

    logic            issue;
    logic            credit_ok;
    logic            bypass_sel;
    logic            pop;
    logic            cancel;
    logic [PC_W-1:0] redirect_target;
    logic [PC_W-1:0] head_pc;

    // A redirect discards the word returning this cycle; it was fetched
    // down the abandoned path.
    assign cancel = i_redirect;

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    logic redirect_misaligned;
    assign redirect_target     = i_redirect_addr;
    assign redirect_misaligned = (i_redirect_addr[1:0] != 2'b00);
`else
    assign redirect_target     = align_word(i_redirect_addr);
`endif

    assign credit_ok = ({1'b0, q_count} + CW'(inflight_reg)) < CW'(QUEUE_DEPTH);

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        tag_next      = tag_reg;
        inflight_next = 1'b0;
        issue         = 1'b0;
        case (state_reg)
            BOOT: state_next = RUN;
            RUN: begin
                if (!i_rst && !i_redirect && credit_ok) begin
                    issue         = 1'b1;
                    pc_next       = pc_reg + PC_STEP;
                    tag_next      = pc_reg;
                    inflight_next = 1'b1;
                end
            end
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
            TRAP: state_next = TRAP;
`endif
            default: state_next = BOOT;
        endcase
        // Redirect overrides whatever the current state decided.
        if (i_redirect) begin
            pc_next = redirect_target;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
            state_next = redirect_misaligned ? TRAP : RUN;
`else
            state_next = RUN;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_ADDR;
            tag_reg      <= RESET_ADDR;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            tag_reg      <= tag_next;
            inflight_reg <= inflight_next;
        end
    end

    // With the queue empty, the returning word is presented straight to
    // decode so a fetch reaches decode one cycle after its request.
    assign bypass_sel   = q_empty && inflight_reg;
    assign o_inst_valid = !q_empty || (inflight_reg && !cancel);
    assign pop          = o_inst_valid && i_inst_ready;
    assign q_pop        = pop && !q_empty;
    // A bypassed word accepted this cycle never enters the queue.
    assign q_push       = inflight_reg && !cancel && !(bypass_sel && pop) && !q_full;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (q_push),
        .i_push_pc   (tag_reg),
        .i_push_inst (i_imem_rdata),
        .i_pop       (q_pop),
        .i_flush     (i_redirect),
        .o_head_pc   (q_head_pc),
        .o_head_inst (q_head_inst),
        .o_count     (q_count),
        .o_full      (q_full),
        .o_empty     (q_empty)
    );

    assign head_pc      = bypass_sel ? tag_reg : q_head_pc;
    assign o_inst       = bypass_sel ? i_imem_rdata : q_head_inst;
    assign o_imem_ren   = issue;
    assign o_imem_raddr = pc_reg;

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    // In TRAP the PC register holds the faulting address.
    assign o_inst_pc    = (state_reg == TRAP) ? pc_reg : head_pc;
    assign o_misaligned = (state_reg == TRAP);
`else
    assign o_inst_pc    = head_pc;
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed, table-driven bench for fetch_sequencer.
// The instruction memory returns (addr ^ 32'hA5A50000) one cycle after a read.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_ren;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_ADDR  (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_redirect      (redirect),
        .i_redirect_addr (redirect_addr),
        .o_imem_ren      (imem_ren),
        .o_imem_raddr    (imem_raddr),
        .i_imem_rdata    (imem_rdata),
        .o_inst_valid    (inst_valid),
        .o_inst          (inst),
        .o_inst_pc       (inst_pc),
        .i_inst_ready    (inst_ready),
        .o_misaligned    (misaligned)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= mem_word(imem_raddr);
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] addr;
        logic        chk;
        logic        e_ren;
        logic [31:0] e_raddr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic rd,
                                input logic [31:0] a, input logic c, input logic en,
                                input logic [31:0] ra, input logic vl, input logic [31:0] pc);
        vec_t v;
        v.rst = r; v.ready = rdy; v.redir = rd; v.addr = a; v.chk = c;
        v.e_ren = en; v.e_raddr = ra; v.e_valid = vl; v.e_pc = pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic rd, input logic [31:0] a);
        @(posedge clk);
        #1;
        rst = r; inst_ready = rdy; redirect = rd; redirect_addr = a;
        @(negedge clk);
    endtask

    task automatic chk_out(input string nm, input logic en, input logic [31:0] ra,
                           input logic vl, input logic [31:0] pc);
        chk({nm, ".ren"}, 32'(imem_ren), 32'(en));
        chk({nm, ".raddr"}, imem_raddr, ra);
        chk({nm, ".valid"}, 32'(inst_valid), 32'(vl));
        if (vl) begin
            chk({nm, ".pc"}, inst_pc, pc);
            chk({nm, ".inst"}, inst, mem_word(pc));
        end
    endtask

    initial begin : main
        logic [31:0] held_pc;
        int          nreq;
        logic [31:0] exp_seq [3];

        // Stall from reset, then drain.
        vecs.push_back(mk(0,0,0,32'h0,1, 0,32'h0, 0,32'h0));          // BOOT
        vecs.push_back(mk(0,0,0,32'h0,1, 1,32'h0, 0,32'h0));          // first request
        vecs.push_back(mk(0,0,0,32'h0,1, 1,32'h4, 1,32'h0));          // first valid
        for (int k = 3; k <= 11; k++)
            vecs.push_back(mk(0,0,0,32'h0,1, 0,32'h8, 1,32'h0));      // credits exhausted
        vecs.push_back(mk(0,1,0,32'h0,1, 0,32'h8, 1,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h8, 1,32'h4));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'hC, 1,32'h8));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h10,1,32'hC));
        // Redirect while the word for 0x8 is returning.
        vecs.push_back(mk(1,1,0,32'h0,0, 0,32'h0, 0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 0,32'h0, 0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h0, 0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h4, 1,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h8, 1,32'h4));
        vecs.push_back(mk(0,1,1,32'h100,1, 0,32'hC, 0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h100,0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h104,1,32'h100));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h108,1,32'h104));
        // Redirect in the same cycle as a pop of queued 0x4.
        vecs.push_back(mk(1,0,0,32'h0,0, 0,32'h0, 0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,1, 0,32'h0, 0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,1, 1,32'h0, 0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,1, 1,32'h4, 1,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 0,32'h8, 1,32'h0));
        vecs.push_back(mk(0,1,1,32'h200,1, 0,32'h8, 1,32'h4));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h200,0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h204,1,32'h200));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h208,1,32'h204));
        // Back-to-back redirects: last one wins.
        vecs.push_back(mk(0,1,1,32'h300,1, 0,32'h20C,0,32'h0));
        vecs.push_back(mk(0,1,1,32'h400,1, 0,32'h300,0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h400,0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h404,1,32'h400));
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
        vecs.push_back(mk(0,1,1,32'h500,1, 0,32'h408,0,32'h0));
`else
        vecs.push_back(mk(0,1,1,32'h502,1, 0,32'h408,0,32'h0));      // low bits dropped
`endif
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h500,0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h504,1,32'h500));
        // PC wrap-around.
        vecs.push_back(mk(0,1,1,32'hFFFF_FFF8,1, 0,32'h508,0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'hFFFF_FFF8,0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'hFFFF_FFFC,1,32'hFFFF_FFF8));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h0,1,32'hFFFF_FFFC));
        vecs.push_back(mk(0,1,0,32'h0,1, 1,32'h4,1,32'h0));

        // Reset values.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ren", 32'(imem_ren), 32'h0);
        chk("rst.raddr", imem_raddr, 32'h0);
        chk("rst.valid", 32'(inst_valid), 32'h0);
        chk("rst.inst", inst, 32'h0);
        chk("rst.pc", inst_pc, 32'h0);
        chk("rst.misaligned", 32'(misaligned), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ready, vecs[i].redir, vecs[i].addr);
            $display("row %0d rst=%b rdy=%b redir=%b ren=%b raddr=%h valid=%b pc=%h",
                     i, vecs[i].rst, vecs[i].ready, vecs[i].redir,
                     imem_ren, imem_raddr, inst_valid, inst_pc);
            if (vecs[i].chk) begin
                chk_out($sformatf("row%0d", i), vecs[i].e_ren, vecs[i].e_raddr,
                        vecs[i].e_valid, vecs[i].e_pc);
                chk($sformatf("row%0d.misaligned", i), 32'(misaligned), 32'h0);
            end
        end

        // Stall from steady state: head 0x4 held, one more request only.
        held_pc = 32'h4;
        nreq    = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 32'h0);
            if (imem_ren) nreq++;
            $display("stall %0d ren=%b valid=%b pc=%h", k, imem_ren, inst_valid, inst_pc);
            chk($sformatf("stall%0d.valid", k), 32'(inst_valid), 32'h1);
            chk($sformatf("stall%0d.pc", k), inst_pc, held_pc);
        end
        chk("stall.requests", 32'(nreq), 32'd1);
        exp_seq[0] = 32'h4; exp_seq[1] = 32'h8; exp_seq[2] = 32'hC;
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 32'h0);
            $display("drain %0d valid=%b pc=%h", k, inst_valid, inst_pc);
            chk($sformatf("drain%0d.valid", k), 32'(inst_valid), 32'h1);
            chk($sformatf("drain%0d.pc", k), inst_pc, exp_seq[k]);
            chk($sformatf("drain%0d.inst", k), inst, mem_word(exp_seq[k]));
        end

        // Reset with a read in flight: its response must be ignored.
        step(1, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        $display("midrst boot ren=%b valid=%b", imem_ren, inst_valid);
        chk_out("midrst.boot", 0, 32'h0, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        chk_out("midrst.req", 1, 32'h0, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        chk_out("midrst.first", 1, 32'h4, 1, 32'h0);

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
        step(0, 1, 1, 32'h102);
        chk_out("trap.enter", 0, 32'h8, 0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 0, 32'h0);
            $display("trap %0d mis=%b pc=%h ren=%b", k, misaligned, inst_pc, imem_ren);
            chk($sformatf("trap%0d.mis", k), 32'(misaligned), 32'h1);
            chk($sformatf("trap%0d.pc", k), inst_pc, 32'h102);
            chk($sformatf("trap%0d.ren", k), 32'(imem_ren), 32'h0);
            chk($sformatf("trap%0d.valid", k), 32'(inst_valid), 32'h0);
        end
        step(0, 1, 1, 32'h106);
        chk("trap.re.mis", 32'(misaligned), 32'h1);
        step(0, 1, 0, 32'h0);
        chk("trap.upd.mis", 32'(misaligned), 32'h1);
        chk("trap.upd.pc", inst_pc, 32'h106);
        chk("trap.upd.ren", 32'(imem_ren), 32'h0);
        step(0, 1, 1, 32'h104);
        chk("trap.exit.ren", 32'(imem_ren), 32'h0);
        step(0, 1, 0, 32'h0);
        chk("trap.resume.mis", 32'(misaligned), 32'h0);
        chk_out("trap.resume", 1, 32'h104, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        chk_out("trap.first", 1, 32'h108, 1, 32'h104);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
